// File: rtl/sif_rx.sv
// sif_rx: receiver for the three-wire sif link. sck/sdat/sen are synchronised to clk,
// and MSB-first words are presented on rdata with single-cycle rvalid / ferr strobes.
module sif_rx #(
   parameter int DW          = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          sck,
   input  logic          sdat,
   input  logic          sen,
   output logic [DW-1:0] rdata,
   output logic          rvalid,
   output logic          ferr,
   output logic          busy
);

   localparam int            CW       = $clog2(DW);
   localparam logic [CW-1:0] LAST_BIT = CW'(DW - 1);

   typedef enum logic [1:0] {
      ST_ARM   = 2'd0,
      ST_IDLE  = 2'd1,
      ST_SHIFT = 2'd2
   } state_t;

   logic [SYNC_STAGES-1:0] r_sck_sync;
   logic [SYNC_STAGES-1:0] r_sdat_sync;
   logic [SYNC_STAGES-1:0] r_sen_sync;
   logic [SYNC_STAGES-1:0] r_prime;
   logic                   r_d_sck;

   state_t                 r_state;
   logic [CW-1:0]          r_cnt;
   logic [DW-2:0]          r_shreg;
   logic [DW-1:0]          r_word;
   logic                   r_done;
   logic                   r_abort;

   logic [DW-1:0]          r_rdata;
   logic                   r_rvalid;
   logic                   r_ferr;
   logic                   r_busy;

   logic                   w_s_sck;
   logic                   w_s_sdat;
   logic                   w_s_sen;
   logic                   w_primed;
   logic                   w_rise;
   logic                   w_last;
   logic [DW-1:0]          w_next_word;
   logic [CW-1:0]          w_cnt_next;

   assign w_s_sck     = r_sck_sync[SYNC_STAGES-1];
   assign w_s_sdat    = r_sdat_sync[SYNC_STAGES-1];
   assign w_s_sen     = r_sen_sync[SYNC_STAGES-1];
   assign w_primed    = r_prime[SYNC_STAGES-1];
   assign w_rise      = w_s_sck & ~r_d_sck;
   assign w_last      = (r_cnt == LAST_BIT);
   assign w_next_word = {r_shreg, w_s_sdat};

   // Synchroniser chains and sck edge flop; r_prime marks when the chains hold real samples.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sck_sync  <= '0;
         r_sdat_sync <= '0;
         r_sen_sync  <= '0;
         r_prime     <= '0;
         r_d_sck     <= 1'b0;
      end else begin
         r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck};
         r_sdat_sync <= {r_sdat_sync[SYNC_STAGES-2:0], sdat};
         r_sen_sync  <= {r_sen_sync[SYNC_STAGES-2:0], sen};
         r_prime     <= {r_prime[SYNC_STAGES-2:0], 1'b1};
         r_d_sck     <= w_s_sck;
      end
   end

   // Bit count after this cycle's rise; a frame close checks this updated value.
   always_comb begin
      w_cnt_next = r_cnt;
      if (w_rise) begin
         if (w_last) begin
            w_cnt_next = '0;
         end else begin
            w_cnt_next = r_cnt + CW'(1);
         end
      end else begin
         w_cnt_next = r_cnt;
      end
   end

   // Frame FSM: ARM refuses to join a frame already running when reset was released.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_ARM;
         r_cnt   <= '0;
         r_shreg <= '0;
         r_word  <= '0;
         r_done  <= 1'b0;
         r_abort <= 1'b0;
      end else begin
         r_done  <= 1'b0;
         r_abort <= 1'b0;
         case (r_state)
            ST_ARM: begin
               if (w_primed && !w_s_sen) begin
                  r_state <= ST_IDLE;
               end
            end
            ST_IDLE: begin
               if (w_s_sen) begin
                  r_state <= ST_SHIFT;
                  r_cnt   <= '0;
                  r_shreg <= '0;
               end
            end
            ST_SHIFT: begin
               if (w_rise) begin
                  r_shreg <= w_next_word[DW-2:0];
                  r_cnt   <= w_cnt_next;
                  if (w_last) begin
                     r_word <= w_next_word;
                     r_done <= 1'b1;
                  end
               end
               if (!w_s_sen) begin
                  r_state <= ST_IDLE;
                  r_abort <= (w_cnt_next != '0);
               end
            end
            default: begin
               r_state <= ST_ARM;
               r_cnt   <= '0;
               r_shreg <= '0;
            end
         endcase
      end
   end

   // Output register stage; rdata only moves when a word completes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
         r_ferr   <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         if (r_done) begin
            r_rdata <= r_word;
         end
         r_rvalid <= r_done;
         r_ferr   <= r_abort;
         r_busy   <= (r_state == ST_SHIFT);
      end
   end

   assign rdata  = r_rdata;
   assign rvalid = r_rvalid;
   assign ferr   = r_ferr;
   assign busy   = r_busy;

endmodule

// File: doc/sif_rx.md
Name: sif_rx

Overview:
Receiver for the three-wire serial interface (sck, sdat, sen) driven by the sif transmitter. All three lines are treated as asynchronous inputs and oversampled on the local system clock. Words are shifted in MSB first and presented on a parallel port with a one-cycle valid strobe. Sits at the far end of the sif link, e.g. inside a peripheral or a loopback test block, feeding register-write or FIFO logic.

Parameters:
DW, 8, data word width in bits (≥2)
SYNC_STAGES, 2, synchronizer depth applied to sck, sdat and sen (≥2)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
sck  input  1  serial clock from transmitter, asynchronous to clk
sdat  input  1  serial data, MSB first, valid at sck rising edge
sen  input  1  frame enable, active high while a frame is being shifted
rdata  output  DW  last completed word
rvalid  output  1  one-clk pulse: rdata updated this cycle
ferr  output  1  one-clk pulse: frame closed with a partial word
busy  output  1  high while in SHIFT state

Behaviour:
- Reset: async assert on rst=0, sync release; rdata=0, rvalid=0, ferr=0, busy=0; state=ARM; bit count, shift register and all sync/edge flops=0.
- Input conditioning: sck, sdat and sen each pass through SYNC_STAGES flops (s_*). One extra flop on s_sck (d_sck) gives rise = s_sck & ~d_sck. sdat passes through the same depth, so s_sdat is aligned with the detected edge.
- Link timing requirement: sck high and low phases each ≥2 clk periods; sdat and sen stable ≥2 clk periods around each sck rising edge. Behaviour outside this is undefined, but the FSM never locks up.
- FSM states ARM, IDLE, SHIFT:
  - ARM: wait for s_sen=0, then go to IDLE. This prevents joining a frame already in progress after reset.
  - IDLE: on s_sen=1, go to SHIFT with count=0 and shift register=0. Rises seen in IDLE are ignored.
  - SHIFT: on each rise, shreg <= {shreg[DW-2:0], s_sdat} and count++.
  - On the rise that completes bit DW (count==DW-1): rdata <= {shreg[DW-2:0], s_sdat}, rvalid=1 on the next cycle, count=0, stay in SHIFT. Back-to-back words within one sen frame are supported.
  - s_sen=0 in SHIFT: go to IDLE. If count≠0, pulse ferr for one cycle, discard the partial word and leave rdata unchanged.
- Simultaneous rise and s_sen fall in the same cycle: the bit is accepted first, then the frame closes. If that bit completes a word, rvalid pulses and ferr does not. Otherwise ferr evaluates the updated count.
- rvalid and ferr are registered, never asserted in the same cycle, and each lasts exactly 1 clk.
- busy is registered and equals (state==SHIFT).
- Latency: from the first clk edge that samples the pin sck high (last bit), rvalid is high after SYNC_STAGES+2 clk edges (4 with default).
- rdata holds its value until the next completed word.
- Reset mid-frame: all state is cleared immediately and the partial word is lost. After release the FSM is in ARM, so the remainder of that frame is ignored until sen is seen low.
- Bit counter width is clog2(DW) and it wraps to 0 only on word completion.

Test Plan:
- Reset: rst=0 with random sck/sdat/sen toggling → rdata=0, rvalid=ferr=busy=0 throughout; state reaches IDLE only after sen is seen low post-release.
- Single word: sen=1, shift 0xCC MSB first (sck period 8 clk), then sen=0 → exactly one rvalid pulse with rdata=0xCC, 4 clk edges after the 8th sck high is sampled; no ferr; busy falls after sen drops.
- Back-to-back: one sen frame carrying 16 bits 0xCC then 0x35 → two rvalid pulses, rdata=0xCC then 0x35; busy stays high between them.
- Abort: sen=1, 5 bits of 0xA5, then sen=0 → one ferr pulse, no rvalid, rdata keeps its previous value (0x35); the next full frame with 0x5A → rvalid with rdata=0x5A.
- Edge race: the 8th sck rise and the sen fall arrive at the pins in the same clk cycle for word 0x81 → rvalid with rdata=0x81, ferr stays 0.
- Mid-frame reset / late start: assert rst after 3 bits, release while sen=1 and shifting continues → no rvalid or ferr for that frame; the following frame 0x3C is received correctly.
